// File: rtl/control_barra.sv
// Paddle movement controller: synchronizes the buttons, issues at most one up/down
// pulse per frame tick, and optionally hands over to an auto-player (BARRA_AUTO_EN).
module control_barra #(
  parameter int unsigned IDLE_TICKS = 600,
  parameter int unsigned REPEAT     = 1,
  parameter int unsigned AI_DIV     = 2,
  parameter int unsigned DEADZONE   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       up,
  output logic       down,
  output logic       mode
);

  logic [1:0] su_q, sd_q;
  logic [7:0] rep_q;
  logic       last_dn_q;
  logic       up_q, down_q;
  logic       su, sd;

  assign su = su_q[1];
  assign sd = sd_q[1];

`ifdef BARRA_AUTO_EN
  typedef enum logic {MANUAL, AUTO} state_e;

  state_e      state_q;
  logic [15:0] idle_q;
  logic [7:0]  ai_q;
  logic        mode_q;
  logic [10:0] ball_x, pad_x, dz;
  logic        ai_up, ai_dn;

  // 11-bit zero-extended compare so the dead zone never wraps around 0 or 1023
  assign ball_x = {1'b0, ball_y};
  assign pad_x  = {1'b0, paddle_y};
  assign dz     = 11'(DEADZONE);
  assign ai_up  = ball_x > (pad_x + dz);
  assign ai_dn  = (ball_x + dz) < pad_x;
  assign mode   = mode_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{ball_y, paddle_y, 16'(IDLE_TICKS), 8'(AI_DIV), 9'(DEADZONE)};
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      su_q      <= '0;
      sd_q      <= '0;
      rep_q     <= '0;
      last_dn_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
`ifdef BARRA_AUTO_EN
      state_q   <= MANUAL;
      idle_q    <= '0;
      ai_q      <= '0;
      mode_q    <= 1'b0;
`endif
    end else begin
      su_q   <= {su_q[0], btn_up};
      sd_q   <= {sd_q[0], btn_down};
      up_q   <= 1'b0;
      down_q <= 1'b0;
`ifdef BARRA_AUTO_EN
      if (state_q == AUTO) begin
        // any button press wins immediately, even over a same-cycle tick
        if (su || sd) begin
          state_q <= MANUAL;
          mode_q  <= 1'b0;
          rep_q   <= '0;
          idle_q  <= '0;
        end else if (tick) begin
          if (ai_q == '0) begin
            up_q   <= ai_up;
            down_q <= ai_dn;
            ai_q   <= 8'(AI_DIV - 1);
          end else begin
            ai_q <= ai_q - 8'd1;
          end
        end
      end else
`endif
      if (tick) begin
        if (su ^ sd) begin
          if (rep_q == '0 || sd != last_dn_q) begin
            up_q      <= su;
            down_q    <= sd;
            rep_q     <= 8'(REPEAT - 1);
            last_dn_q <= sd;
          end else begin
            rep_q <= rep_q - 8'd1;
          end
        end else begin
          rep_q <= '0;
        end
`ifdef BARRA_AUTO_EN
        if (su || sd) begin
          idle_q <= '0;
        end else if (idle_q == 16'(IDLE_TICKS - 1)) begin
          state_q <= AUTO;
          mode_q  <= 1'b1;
          ai_q    <= '0;
          idle_q  <= '0;
        end else begin
          idle_q <= idle_q + 16'd1;
        end
`endif
      end
    end
  end

  assign up   = up_q;
  assign down = down_q;

endmodule

// File: doc/control_barra.md
Name: control_barra

Overview:
- Movement controller that sequences the paddle block's up/down inputs.
- Arbitrates between a human player (push buttons) and a built-in auto-player that tracks the ball.
- Emits at most one single-cycle move pulse per frame tick.
- Sits between the button inputs / frame-tick generator and the paddle position register. Paddle y increases on "up".

Parameters:
- IDLE_TICKS, 600, button-free ticks in MANUAL before handing control to AUTO (10 s at 60 Hz); range 1..65535
- REPEAT, 1, while a button is held, one pulse every REPEAT ticks; range 1..255
- AI_DIV, 2, AUTO evaluates once every AI_DIV ticks; range 1..255
- DEADZONE, 8, pixel tolerance between ball_y and paddle_y within which AUTO does not move; range 0..511

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  frame strobe, one clk wide, once per frame
- btn_up  in  1  raw up button, asynchronous
- btn_down  in  1  raw down button, asynchronous
- ball_y  in  10  current ball vertical position
- paddle_y  in  10  current paddle position, fed back from the paddle block
- up  out  1  move-up pulse to the paddle block
- down  out  1  move-down pulse to the paddle block
- mode  out  1  0 = MANUAL, 1 = AUTO

Behaviour:
- Reset: synchronous, active-high.
  - up = 0, down = 0, mode = 0.
  - State MANUAL; idle, rep and ai counters = 0; 2-flop synchronizers cleared.
  - Reset asserted mid-operation aborts any pending pulse in the following cycle.
- Synchronization: btn_up and btn_down each pass a 2-flop synchronizer (su, sd). All decisions use su/sd, so a button change is visible 2 clk later.
- Output timing:
  - up/down are registered and high for exactly one clk, in the cycle after the tick cycle.
  - Outside that cycle both are 0. up and down are never high together.
  - mode is registered and changes the cycle after the transition condition.
- State MANUAL, evaluated on each tick:
  - Exactly one of su/sd high:
    - If rep == 0 or the direction differs from the last pulsed direction: pulse that direction, rep <= REPEAT-1, record the direction.
    - Otherwise rep <= rep-1, no pulse.
  - Both high or both low: no pulse, rep <= 0.
  - Any of su/sd high: idle <= 0.
  - Both low: idle <= idle+1. When idle == IDLE_TICKS-1 on that tick, go to AUTO, ai <= 0, idle <= 0.
- State AUTO:
  - Any cycle with su or sd high: go to MANUAL next cycle with rep <= 0 and idle <= 0. No pulse of either kind is issued that cycle, even if tick is high.
  - On tick, if ai == 0, compare using 11-bit zero-extended arithmetic (no wrap):
    - ball_y > paddle_y + DEADZONE: pulse up.
    - ball_y + DEADZONE < paddle_y: pulse down.
    - Otherwise no pulse.
    - Then ai <= AI_DIV-1.
  - On tick with ai != 0: ai <= ai-1, no pulse.
- Boundaries:
  - The paddle block's own saturation handles its min/max; this block does not clamp.
  - All counters stay within their parameter ranges and never wrap.
  - Ticks arriving on consecutive clk cycles are each honoured.

Optional Feature:
- Macro BARRA_AUTO_EN.
- Defined: AUTO state and ai counter present; behaviour as above.
- Undefined:
  - AUTO logic and the idle/ai counters are not built.
  - mode is tied to 0 and the block is MANUAL-only.
  - ball_y is unused.
  - Manual pulsing is unchanged.

Test Plan:
- MANUAL, REPEAT = 1: reset, hold btn_up, apply ticks every 100 clk -> one up pulse 1 clk after each tick; down = 0; mode = 0.
- Repeat and direction change, REPEAT = 3: hold btn_up across 7 ticks -> up pulses on ticks 1, 4 and 7 only. Switch to btn_down at tick 8 -> down pulse on tick 8 immediately.
- Both buttons held, 5 ticks -> no pulses; idle stays 0; mode stays 0.
- Idle handover, IDLE_TICKS = 4, AI_DIV = 1, DEADZONE = 8: no buttons for 4 ticks -> mode = 1 after tick 4. Then:
  - paddle_y = 100, ball_y = 120 -> up on next tick.
  - ball_y = 105 -> no pulse.
  - ball_y = 80 -> down.
  - ball_y = 0, paddle_y = 5 -> no pulse (no wrap).
- Takeover: in AUTO, assert btn_down in the same cycle as tick (accounting for sync delay) -> no pulse that tick; mode = 0 next cycle; down pulse on the following tick.
- Reset mid-hold: assert reset in the tick cycle while btn_up is held -> up stays 0; counters cleared; mode = 0. First pulse appears only after btn_up is re-synchronized (2 clk) and the next tick.
